// File: rtl/dmem_responder_pkg.sv
// Shared constants and types for the data-memory responder and its RAM.
// Byte lanes are fixed at four 8-bit lanes, so WORD is expected to be 32.
package dmem_responder_pkg;

    localparam int unsigned WORD_BITS = 32;
    localparam int unsigned LANES     = 4;

    // memWrite encoding from the decoder
    localparam logic LOAD  = 1'b0;
    localparam logic STORE = 1'b1;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x WORD synchronous RAM with per-byte write enables and a registered read.
// Contents are deliberately not reset.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int unsigned WORD  = WORD_BITS,
    parameter int unsigned DEPTH = 1024,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic [LANES-1:0] we,
    input  logic [AW-1:0]    addr,
    input  logic [WORD-1:0]  wdata,
    output logic [WORD-1:0]  rdata
);

    logic [WORD-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < int'(LANES); b++) begin
                if (we[b]) begin
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: accepts one request, accesses dmem_array, then holds a
// registered response until the requester takes it. No request overlap.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned WORD  = WORD_BITS,
    parameter int unsigned DEPTH = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      req_funct3,
    input  logic [WORD-1:0] req_addr,
    input  logic [WORD-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [WORD-1:0] rsp_rdata,
    output logic            rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_t          state_q, state_d;
    logic            write_q;
    logic [2:0]      funct3_q;
    logic [WORD-1:0] addr_q;
    logic [WORD-1:0] wdata_q;
    logic            rsp_valid_q;
    logic [WORD-1:0] rsp_rdata_q;
    logic            rsp_err_q;

    logic [1:0]       lane;
    logic [WORD-3:0]  word_idx;
    logic             legal_f3;
    logic             misaligned;
    logic             out_of_range;
    logic             fault;
    logic [LANES-1:0] be;
    logic [WORD-1:0]  wdata_lanes;
    logic [LANES-1:0] ram_we;
    logic             ram_en;
    logic [WORD-1:0]  ram_rdata;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [WORD-1:0]  load_data;

    // Request decode works off the captured request, so it is stable from
    // ACCESS through the end of RESP.
    always_comb begin
        lane         = addr_q[1:0];
        word_idx     = addr_q[WORD-1:2];
        legal_f3     = write_q ? (funct3_q inside {SB, SH, SW})
                               : (funct3_q inside {LB, LH, LW, LBU, LHU});
        misaligned   = 1'b0;
        be           = '0;
        wdata_lanes  = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                be          = 4'b0001 << lane;
                wdata_lanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                misaligned  = addr_q[0];
                be          = 4'b0011 << {lane[1], 1'b0};
                wdata_lanes = {2{wdata_q[15:0]}};
            end
            2'b10: begin
                misaligned  = |lane;
                be          = 4'b1111;
            end
            default: ;
        endcase
        out_of_range = {2'b00, word_idx} >= WORD'(DEPTH);
        fault        = !legal_f3 || misaligned || out_of_range;
    end

    // Write enables derive from the (async-reset) state, so a reset during
    // ACCESS suppresses the write at the following edge.
    assign ram_en = (state_q == StAccess);
    assign ram_we = (ram_en && write_q && !fault) ? be : '0;

    dmem_array #(
        .WORD  (WORD),
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (word_idx[AW-1:0]),
        .wdata (wdata_lanes),
        .rdata (ram_rdata)
    );

    always_comb begin
        byte_sel  = ram_rdata[{lane, 3'b000} +: 8];
        half_sel  = lane[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        load_data = '0;
        case (funct3_q)
            LB:      load_data = {{(WORD-8){byte_sel[7]}}, byte_sel};
            LH:      load_data = {{(WORD-16){half_sel[15]}}, half_sel};
            LW:      load_data = ram_rdata;
            LBU:     load_data = {{(WORD-8){1'b0}}, byte_sel};
            LHU:     load_data = {{(WORD-16){1'b0}}, half_sel};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        req_ready = (state_q == StIdle);
        unique case (state_q)
            StIdle:   if (req_valid) state_d = StAccess;
            StAccess: state_d = StResp;
            StResp:   if (rsp_valid_q && rsp_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            write_q     <= 1'b0;
            funct3_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && req_valid) begin
                write_q  <= req_write;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end
            // First RESP cycle registers the RAM read; afterwards hold until taken.
            if (state_q == StResp && !rsp_valid_q) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= (fault || write_q) ? '0 : load_data;
                rsp_err_q   <= fault;
            end else if (state_q == StResp && rsp_ready) begin
                rsp_valid_q <= 1'b0;
                rsp_rdata_q <= '0;
                rsp_err_q   <= 1'b0;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder with hand-computed expectations.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    dmem_responder #(
        .WORD  (32),
        .DEPTH (1024)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge in IDLE; returns 1ns after the edge where
    // rsp_valid must first be high (two edges after the accept edge).
    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        check("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rsp_valid_access", 32'(rsp_valid), 32'd0);
        check("req_ready_access", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check("rsp_valid_early", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("rsp_valid_latency", 32'(rsp_valid), 32'd1);
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_valid_after_ack", 32'(rsp_valid), 32'd0);
    endtask

    task automatic txn(input string tag, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rdata, input logic exp_err);
        issue(w, f3, a, d);
        check({tag, "_rdata"}, rsp_rdata, exp_rdata);
        check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        ack();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b0;
        #3;
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", 32'(req_ready), 32'd1);

        txn("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        txn("lw_10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        txn("lb_13", 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
        txn("lbu_13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0);
        txn("lh_12", 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
        txn("lhu_10", 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0);

        // Lane 1 of 0xDEADBEEF is 0xBE; replacing it gives 0xDEADAAEF.
        txn("sb_11", 1'b1, 3'b000, 32'h11, 32'h000000AA, 32'h0, 1'b0);
        txn("lw_after_sb", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADAAEF, 1'b0);

        txn("lw_misal", 1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1);
        txn("sh_misal", 1'b1, 3'b001, 32'h13, 32'h0000FFFF, 32'h0, 1'b1);
        txn("lw_oor", 1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1);
        txn("ld_illegal", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
        txn("st_illegal", 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1);
        txn("lw_after_faults", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADAAEF, 1'b0);

        txn("sh_12", 1'b1, 3'b001, 32'h12, 32'hFFFF1234, 32'h0, 1'b0);
        txn("lw_after_sh", 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234AAEF, 1'b0);
        txn("lb_11", 1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFAA, 1'b0);

        txn("sw_last", 1'b1, 3'b010, 32'hFFC, 32'h5A5A0001, 32'h0, 1'b0);
        txn("lw_last", 1'b0, 3'b010, 32'hFFC, 32'h0, 32'h5A5A0001, 1'b0);

        // Hold the response while a store request toggles on the input.
        issue(1'b0, 3'b010, 32'h10, 32'h0);
        req_write  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        req_wdata  = 32'hFFFFFFFF;
        for (int i = 0; i < 5; i++) begin
            req_valid = ~req_valid;
            @(posedge clk); #1;
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_rsp_rdata", rsp_rdata, 32'h1234AAEF);
            check("hold_rsp_err", 32'(rsp_err), 32'd0);
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        ack();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("no_ghost_rsp", 32'(rsp_valid), 32'd0);
        end
        txn("lw_after_hold", 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234AAEF, 1'b0);

        // Reset during ACCESS must abort the store.
        txn("sw_20", 1'b1, 3'b010, 32'h20, 32'h0BADF00D, 32'h0, 1'b0);
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h20;
        req_wdata  = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("abort_in_access", 32'(req_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_rsp_rdata", rsp_rdata, 32'd0);
        check("abort_rsp_err", 32'(rsp_err), 32'd0);
        check("abort_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_abort", 32'(req_ready), 32'd1);
        check("no_rsp_after_abort", 32'(rsp_valid), 32'd0);
        txn("lw_20_prior", 1'b0, 3'b010, 32'h20, 32'h0, 32'h0BADF00D, 1'b0);

        // Reset during RESP drops the response without replay.
        issue(1'b0, 3'b010, 32'h20, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check("drop_rsp_valid", 32'(rsp_valid), 32'd0);
        check("drop_rsp_rdata", rsp_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("no_replay", 32'(rsp_valid), 32'd0);
        end
        txn("lw_final", 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234AAEF, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
